// File: rtl/shift_arbiter_rr.sv
// shift_arbiter_rr: round-robin arbiter in front of one shared 32-bit shifter.
// Each requester has a valid/ready port. Results land in a one-entry
// registered slot that hands off to a single consumer.
// Optional feature: define ROR_EN so that op 2'b11 becomes rotate-right.
// Without it, op 2'b11 is still accepted, but its result is 0 with res_err=1.
module shift_arbiter_rr #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*5-1:0]    req_shamt,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [31:0]     res_data_q;
  logic [ID_W-1:0] res_id_q;
  logic            res_err_q;

  // Per-requester views of the flattened operand buses
  logic [31:0]     op_a    [NREQ];
  logic [4:0]      op_sh   [NREQ];
  logic [1:0]      op_code [NREQ];
  // cand_idx[k] is the requester visited k-th in the round-robin scan
  logic [ID_W-1:0] cand_idx [NREQ];

  logic            can_accept;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            grant_fire;
  logic [ID_W-1:0] next_ptr;

  logic [31:0]     sel_a;
  logic [4:0]      sel_sh;
  logic [1:0]      sel_op;
  logic [31:0]     shift_res;
  logic            shift_err;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign op_a[gi]    = req_a[32*gi +: 32];
      assign op_sh[gi]   = req_shamt[5*gi +: 5];
      assign op_code[gi] = req_op[2*gi +: 2];
      if (gi == 0) begin : g_first
        assign cand_idx[gi] = rr_ptr_q;
      end else begin : g_rest
        // (rr_ptr + gi) mod NREQ without widening past ID_W
        assign cand_idx[gi] = (rr_ptr_q >= ID_W'(NREQ - gi)) ?
                              (rr_ptr_q - ID_W'(NREQ - gi)) :
                              (rr_ptr_q + ID_W'(gi));
      end
    end
  endgenerate

  // The slot can take a result if it is empty or is being drained this cycle
  assign can_accept = (state_q == EMPTY) | (res_valid & res_ready);
  assign grant_fire = can_accept & grant_found & ~rst;
  assign next_ptr   = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Scan from the highest offset down so the closest valid requester to rr_ptr wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // One-hot ready for the winner, only in a cycle where the slot can take it
  always_comb begin
    req_ready = '0;
    if (grant_fire) req_ready[grant_idx] = 1'b1;
  end

  // Shared barrel shifter fed by the granted requester's operands
  always_comb begin
    sel_a     = op_a[grant_idx];
    sel_sh    = op_sh[grant_idx];
    sel_op    = op_code[grant_idx];
    shift_err = 1'b0;
    case (sel_op)
      2'b00:   shift_res = sel_a << sel_sh;
      2'b01:   shift_res = sel_a >> sel_sh;
      2'b10:   shift_res = $unsigned($signed(sel_a) >>> sel_sh);
      default: begin
`ifdef ROR_EN
        // A shift by 32 yields 0, so shamt 0 falls out as a plain copy
        shift_res = (sel_a >> sel_sh) | (sel_a << (6'd32 - {1'b0, sel_sh}));
`else
        shift_res = '0;
        shift_err = 1'b1;
`endif
      end
    endcase
  end

  // Slot FSM: load on grant, empty on an unreplaced drain, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_err_q  <= 1'b0;
    end else if (grant_fire) begin
      state_q    <= FULL;
      rr_ptr_q   <= next_ptr;
      res_data_q <= shift_res;
      res_id_q   <= grant_idx;
      res_err_q  <= shift_err;
    end else if (can_accept) begin
      state_q    <= EMPTY;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;

endmodule
